// File: rtl/dispatch_queue.sv
// In-order dispatch buffer between decode and RS/LSB/ROB; one entry in, one entry out per cycle.
// Latency: one edge minimum from enqueue to registered dispatch strobe; a blocked head holds every younger entry.
module dispatch_queue #(
  parameter int INST_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5,
  parameter int IMM_W  = 32,
  parameter int DEPTH  = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] up_inst,
  input  logic [ADDR_W-1:0] up_npc,
  input  logic [REG_W-1:0]  up_rs1,
  input  logic [REG_W-1:0]  up_rs2,
  input  logic [REG_W-1:0]  up_rd,
  input  logic              up_rs1_in_need,
  input  logic              up_rs2_in_need,
  input  logic              up_rd_in_need,
  input  logic              mem_in_need,
  input  logic [IMM_W-1:0]  up_imme,
  input  logic              rs_full,
  input  logic              lsb_full,
  input  logic              rob_full,
  output logic [INST_W-1:0] to_inst,
  output logic [ADDR_W-1:0] to_npc,
  output logic [REG_W-1:0]  to_rs1,
  output logic [REG_W-1:0]  to_rs2,
  output logic [REG_W-1:0]  to_rd,
  output logic              to_rs1_in_need,
  output logic              to_rs2_in_need,
  output logic              to_rd_in_need,
  output logic [IMM_W-1:0]  to_imme,
  output logic              dispatch_rs_rdy,
  output logic              dispatch_lsb_rdy,
  output logic              dispatch_rob_rdy,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic [15:0]       stall_cnt
);

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] npc;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic              rs1_need;
    logic              rs2_need;
    logic              rd_need;
    logic              mem;
    logic [IMM_W-1:0]  imm;
  } ent_t;

  ent_t          slots_q [DEPTH];
  ent_t          wr_e, head_e, out_q, out_d;
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   stall_q, stall_d;
  logic          enq, disp, rd_keep;
  logic          rs_q, lsb_q, rob_q;

  assign in_ready = rst_in & rdy_in & ~clear & (count_q < CW'(DEPTH));
  assign enq      = in_valid & in_ready;
  assign head_e   = slots_q[head_q];
  assign disp     = (count_q != '0) & rdy_in & ~clear & ~rob_full &
                    (head_e.mem ? ~lsb_full : ~rs_full);

  // x0 is never renamed, so its destination is dropped before storage.
  assign rd_keep = up_rd_in_need & (up_rd != '0);
  always_comb begin
    wr_e.inst     = up_inst;
    wr_e.npc      = up_npc;
    wr_e.rs1      = up_rs1;
    wr_e.rs2      = up_rs2;
    wr_e.rd       = rd_keep ? up_rd : '0;
    wr_e.rs1_need = up_rs1_in_need;
    wr_e.rs2_need = up_rs2_in_need;
    wr_e.rd_need  = rd_keep;
    wr_e.mem      = mem_in_need;
    wr_e.imm      = up_imme;
  end

  always_comb begin
    count_d = count_q;
    case ({enq, disp})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    stall_d = stall_q;
    if ((count_q != '0) && rdy_in && !clear && !disp && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
    out_d = disp ? head_e : '0;
  end

  always_ff @(posedge clk_in) begin
    if (enq) slots_q[tail_q] <= wr_e;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stall_q <= '0;
      out_q   <= '0;
      rs_q    <= 1'b0;
      lsb_q   <= 1'b0;
      rob_q   <= 1'b0;
    end else begin
      out_q <= out_d;
      rob_q <= disp;
      lsb_q <= disp & head_e.mem;
      rs_q  <= disp & ~head_e.mem;
      if (clear) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else if (rdy_in) begin
        if (enq)  tail_q <= tail_q + 1'b1;
        if (disp) head_q <= head_q + 1'b1;
        count_q <= count_d;
        stall_q <= stall_d;
      end
    end
  end

  assign to_inst          = out_q.inst;
  assign to_npc           = out_q.npc;
  assign to_rs1           = out_q.rs1;
  assign to_rs2           = out_q.rs2;
  assign to_rd            = out_q.rd;
  assign to_rs1_in_need   = out_q.rs1_need;
  assign to_rs2_in_need   = out_q.rs2_need;
  assign to_rd_in_need    = out_q.rd_need;
  assign to_imme          = out_q.imm;
  assign dispatch_rs_rdy  = rs_q;
  assign dispatch_lsb_rdy = lsb_q;
  assign dispatch_rob_rdy = rob_q;
  assign count            = count_q;
  assign empty            = (count_q == '0);
  assign stall_cnt        = stall_q;

endmodule

// File: tb/tb_dispatch_queue.sv
// Randomized and directed bench for dispatch_queue against a queue-based reference model.
module tb_dispatch_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] npc;
    logic [4:0]  rs1, rs2, rd;
    logic        rs1n, rs2n, rdn, mem;
    logic [31:0] imm;
  } ent_t;

  logic clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b0, clear = 1'b0, in_valid = 1'b0;
  logic in_ready;
  logic [31:0] up_inst = '0, up_npc = '0, up_imme = '0;
  logic [4:0]  up_rs1 = '0, up_rs2 = '0, up_rd = '0;
  logic up_rs1_in_need = 0, up_rs2_in_need = 0, up_rd_in_need = 0, mem_in_need = 0;
  logic rs_full = 0, lsb_full = 0, rob_full = 0;
  logic [31:0] to_inst, to_npc, to_imme;
  logic [4:0]  to_rs1, to_rs2, to_rd;
  logic to_rs1_in_need, to_rs2_in_need, to_rd_in_need;
  logic dispatch_rs_rdy, dispatch_lsb_rdy, dispatch_rob_rdy;
  logic [2:0]  count;
  logic        empty;
  logic [15:0] stall_cnt;

  always #5 clk_in = ~clk_in;

  dispatch_queue #(.INST_W(32), .ADDR_W(32), .REG_W(5), .IMM_W(32), .DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .up_inst(up_inst), .up_npc(up_npc), .up_rs1(up_rs1), .up_rs2(up_rs2), .up_rd(up_rd),
    .up_rs1_in_need(up_rs1_in_need), .up_rs2_in_need(up_rs2_in_need),
    .up_rd_in_need(up_rd_in_need), .mem_in_need(mem_in_need), .up_imme(up_imme),
    .rs_full(rs_full), .lsb_full(lsb_full), .rob_full(rob_full),
    .to_inst(to_inst), .to_npc(to_npc), .to_rs1(to_rs1), .to_rs2(to_rs2), .to_rd(to_rd),
    .to_rs1_in_need(to_rs1_in_need), .to_rs2_in_need(to_rs2_in_need),
    .to_rd_in_need(to_rd_in_need), .to_imme(to_imme),
    .dispatch_rs_rdy(dispatch_rs_rdy), .dispatch_lsb_rdy(dispatch_lsb_rdy),
    .dispatch_rob_rdy(dispatch_rob_rdy), .count(count), .empty(empty), .stall_cnt(stall_cnt)
  );

  int   n_tests = 0, n_fail = 0;
  ent_t q[$];
  int   m_stall = 0;
  logic e_rs = 0, e_lsb = 0, e_rob = 0;
  logic [127:0] e_pay = '0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] pay_of(input ent_t e);
    return {14'd0, e.inst, e.npc, e.rs1, e.rs2, e.rd, e.rs1n, e.rs2n, e.rdn, e.imm};
  endfunction

  function automatic logic [127:0] dut_pay();
    return {14'd0, to_inst, to_npc, to_rs1, to_rs2, to_rd,
            to_rs1_in_need, to_rs2_in_need, to_rd_in_need, to_imme};
  endfunction

  function automatic ent_t rand_ent();
    ent_t e;
    e.inst = $urandom; e.npc = $urandom; e.imm = $urandom;
    e.rs1 = 5'($urandom); e.rs2 = 5'($urandom);
    e.rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    e.rs1n = 1'($urandom); e.rs2n = 1'($urandom); e.rdn = 1'($urandom); e.mem = 1'($urandom);
    return e;
  endfunction

  function automatic ent_t mk(input logic [4:0] rd, input logic rdn, input logic mem);
    ent_t e = rand_ent();
    e.rd = rd; e.rdn = rdn; e.mem = mem;
    return e;
  endfunction

  task automatic chk_outs(input string tag);
    check_val({tag, ".count"}, 128'(count), 128'(q.size()));
    check_val({tag, ".empty"}, 128'(empty), 128'(q.size() == 0));
    check_val({tag, ".rs"}, 128'(dispatch_rs_rdy), 128'(e_rs));
    check_val({tag, ".lsb"}, 128'(dispatch_lsb_rdy), 128'(e_lsb));
    check_val({tag, ".rob"}, 128'(dispatch_rob_rdy), 128'(e_rob));
    check_val({tag, ".pay"}, dut_pay(), e_pay);
    check_val({tag, ".stall"}, 128'(stall_cnt), 128'(m_stall));
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input string tag, input logic v, input logic rsf, input logic lsbf,
                      input logic robf, input logic clr, input logic rdy, input ent_t e);
    bit ok, inr, dsp;
    ent_t s;
    in_valid = v; rs_full = rsf; lsb_full = lsbf; rob_full = robf; clear = clr; rdy_in = rdy;
    up_inst = e.inst; up_npc = e.npc; up_rs1 = e.rs1; up_rs2 = e.rs2; up_rd = e.rd;
    up_rs1_in_need = e.rs1n; up_rs2_in_need = e.rs2n; up_rd_in_need = e.rdn;
    mem_in_need = e.mem; up_imme = e.imm;
    #1;
    ok  = rdy && !clr;
    inr = ok && (q.size() < DEPTH);
    check_val({tag, ".in_ready"}, 128'(in_ready), 128'(inr));
    check_val({tag, ".pre_count"}, 128'(count), 128'(q.size()));
    dsp = ok && (q.size() > 0) && !robf && (q[0].mem ? !lsbf : !rsf);
    e_rs = 0; e_lsb = 0; e_rob = 0; e_pay = '0;
    if (clr) begin
      q.delete();
    end else if (ok) begin
      if (dsp) begin
        e_pay = pay_of(q[0]);
        e_rob = 1; e_lsb = q[0].mem; e_rs = !q[0].mem;
        void'(q.pop_front());
      end else if (q.size() > 0 && m_stall < 65535) begin
        m_stall++;
      end
      if (v && inr) begin
        s = e;
        if (!e.rdn || e.rd == 0) begin s.rd = 0; s.rdn = 0; end
        q.push_back(s);
      end
    end
    @(posedge clk_in); #1;
    chk_outs(tag);
    @(negedge clk_in);
  endtask

  task automatic idle(input string tag, input logic robf);
    step(tag, 0, 0, 0, robf, 0, 1, rand_ent());
  endtask

  initial begin
    #3;
    check_val("rst.count", 128'(count), 0);
    check_val("rst.empty", 128'(empty), 1);
    check_val("rst.in_ready", 128'(in_ready), 0);
    check_val("rst.strobes", 128'({dispatch_rs_rdy, dispatch_lsb_rdy, dispatch_rob_rdy}), 0);
    check_val("rst.pay", dut_pay(), 0);
    check_val("rst.stall", 128'(stall_cnt), 0);
    @(negedge clk_in);
    rst_in = 1;

    step("single", 1, 0, 0, 0, 0, 1, mk(5'd5, 1, 0));
    check_val("single.no_bypass", 128'(dispatch_rob_rdy), 0);
    idle("single_disp", 0);
    check_val("single.to_rd", 128'(to_rd), 5);
    check_val("single.rs_rdy", 128'(dispatch_rs_rdy), 1);
    idle("single_after", 0);

    for (int i = 0; i < 6; i++) step("fill", 1, 0, 0, 1, 0, 1, mk(5'(i + 1), 1, 0));
    check_val("fill.count", 128'(count), 4);
    for (int i = 0; i < 5; i++) idle("drain", 0);

    step("ord_mem", 1, 0, 1, 0, 0, 1, mk(5'd3, 1, 1));
    step("ord_alu", 1, 0, 1, 0, 0, 1, mk(5'd4, 1, 0));
    step("ord_blk", 0, 0, 1, 0, 0, 1, rand_ent());
    check_val("ord.blocked", 128'(dispatch_rs_rdy), 0);
    for (int i = 0; i < 3; i++) step("ord_go", 0, 0, 0, 0, 0, 1, rand_ent());

    for (int i = 0; i < 3; i++) step("clr_fill", 1, 0, 0, 1, 0, 1, rand_ent());
    step("clr", 1, 0, 0, 0, 1, 1, rand_ent());
    check_val("clr.empty", 128'(empty), 1);
    idle("clr_after", 0);

    step("x0", 1, 0, 0, 0, 0, 1, mk(5'd0, 1, 0));
    idle("x0_disp", 0);
    check_val("x0.rd_need", 128'(to_rd_in_need), 0);

    for (int i = 0; i < 3000; i++)
      step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) != 0), rand_ent());

    for (int i = 0; i < 6; i++) idle("pre_sat", 0);
    step("sat_a", 1, 0, 0, 1, 0, 1, rand_ent());
    step("sat_b", 1, 0, 0, 1, 0, 1, rand_ent());
    for (int i = 0; i < 65600; i++) idle("sat", 1);
    check_val("sat.stall", 128'(stall_cnt), 16'hFFFF);
    check_val("sat.count", 128'(count), 2);

    #2 rst_in = 0;
    #1;
    q.delete(); m_stall = 0; e_rs = 0; e_lsb = 0; e_rob = 0; e_pay = '0;
    check_val("arst.in_ready", 128'(in_ready), 0);
    chk_outs("arst");
    @(negedge clk_in);
    rst_in = 1;
    for (int i = 0; i < 300; i++)
      step("post", ($urandom_range(0, 1) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0), rand_ent());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
